// File: rtl/alu_sequencer.sv
// Execute-phase controller for the DataPath register/ALU array.
// Optional MUL/DIV path (LO then HI write-back) enabled by defining SEQ_MULDIV_EN.
module alu_sequencer #(
  parameter int NREGS  = 16,
  parameter int RIDX_W = 4,
  parameter int OP_W   = 5
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              start,
  input  logic [OP_W-1:0]   opcode,
  input  logic [RIDX_W-1:0] ra,
  input  logic [RIDX_W-1:0] rb,
  input  logic [RIDX_W-1:0] rc,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [NREGS-1:0]  reg_out,
  output logic [NREGS-1:0]  reg_in,
  output logic              RYin,
  output logic              RZin,
  output logic              RZLOout,
  output logic              RZHIout,
  output logic              LOin,
  output logic              HIin,
  output logic [OP_W-1:0]   ops
);

  typedef enum logic [OP_W-1:0] {
    OP_ADD = OP_W'(0),  OP_SUB = OP_W'(1),  OP_AND = OP_W'(2),  OP_OR  = OP_W'(3),
    OP_SHR = OP_W'(4),  OP_SHL = OP_W'(5),  OP_ROR = OP_W'(6),  OP_ROL = OP_W'(7),
    OP_MUL = OP_W'(8),  OP_DIV = OP_W'(9),  OP_NEG = OP_W'(10), OP_NOT = OP_W'(11)
  } opcode_t;

`ifdef SEQ_MULDIV_EN
  typedef enum logic [2:0] {IDLE, T_LDY, T_ALU, T_WLO, T_WHI} state_t;
`else
  typedef enum logic [1:0] {IDLE, T_LDY, T_ALU, T_WLO} state_t;
`endif

  state_t              state, nxt_state;
  logic [OP_W-1:0]     op_q, nxt_op;
  logic [RIDX_W-1:0]   ra_q, rb_q, rc_q, nxt_ra, nxt_rb, nxt_rc;
  logic                nxt_error;

  logic                d_busy, d_done, d_ryin, d_rzin, d_rzlo;
  logic [NREGS-1:0]    d_reg_out, d_reg_in;
  logic [OP_W-1:0]     d_ops;

  function automatic logic is_unary(input logic [OP_W-1:0] op);
    return (op == OP_NEG) || (op == OP_NOT);
  endfunction

  function automatic logic is_muldiv(input logic [OP_W-1:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

  function automatic logic is_legal(input logic [OP_W-1:0] op);
`ifdef SEQ_MULDIV_EN
    return op <= OP_NOT;
`else
    return (op <= OP_NOT) && !is_muldiv(op);
`endif
  endfunction

  always_comb begin
    nxt_state = state;
    nxt_op    = op_q;
    nxt_ra    = ra_q;
    nxt_rb    = rb_q;
    nxt_rc    = rc_q;
    nxt_error = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (is_legal(opcode)) begin
            nxt_op    = opcode;
            nxt_ra    = ra;
            nxt_rb    = rb;
            nxt_rc    = rc;
            nxt_state = is_unary(opcode) ? T_ALU : T_LDY;
          end else begin
            nxt_error = 1'b1;
          end
        end
      end
      T_LDY: nxt_state = T_ALU;
      T_ALU: nxt_state = T_WLO;
`ifdef SEQ_MULDIV_EN
      T_WLO: nxt_state = is_muldiv(op_q) ? T_WHI : IDLE;
      T_WHI: nxt_state = IDLE;
`else
      T_WLO: nxt_state = IDLE;
`endif
      default: nxt_state = IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state and fields, then registered,
  // so each strobe appears in the same cycle as the state it belongs to.
`ifdef SEQ_MULDIV_EN
  logic d_rzhi, d_loin, d_hiin;
`endif

  always_comb begin
    d_busy    = (nxt_state != IDLE);
    d_done    = 1'b0;
    d_ryin    = 1'b0;
    d_rzin    = 1'b0;
    d_rzlo    = 1'b0;
    d_reg_out = '0;
    d_reg_in  = '0;
    d_ops     = d_busy ? nxt_op : '0;
`ifdef SEQ_MULDIV_EN
    d_rzhi    = 1'b0;
    d_loin    = 1'b0;
    d_hiin    = 1'b0;
`endif
    case (nxt_state)
      T_LDY: begin
        d_reg_out = NREGS'(1) << nxt_rb;
        d_ryin    = 1'b1;
      end
      T_ALU: begin
        d_reg_out = NREGS'(1) << (is_unary(nxt_op) ? nxt_rb : nxt_rc);
        d_rzin    = 1'b1;
      end
      T_WLO: begin
        d_rzlo = 1'b1;
`ifdef SEQ_MULDIV_EN
        if (is_muldiv(nxt_op)) begin
          d_loin = 1'b1;
        end else begin
          d_reg_in = NREGS'(1) << nxt_ra;
          d_done   = 1'b1;
        end
`else
        d_reg_in = NREGS'(1) << nxt_ra;
        d_done   = 1'b1;
`endif
      end
`ifdef SEQ_MULDIV_EN
      T_WHI: begin
        d_rzhi = 1'b1;
        d_hiin = 1'b1;
        d_done = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state   <= IDLE;
      op_q    <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      rc_q    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      error   <= 1'b0;
      reg_out <= '0;
      reg_in  <= '0;
      RYin    <= 1'b0;
      RZin    <= 1'b0;
      RZLOout <= 1'b0;
      ops     <= '0;
    end else begin
      state   <= nxt_state;
      op_q    <= nxt_op;
      ra_q    <= nxt_ra;
      rb_q    <= nxt_rb;
      rc_q    <= nxt_rc;
      busy    <= d_busy;
      done    <= d_done;
      error   <= nxt_error;
      reg_out <= d_reg_out;
      reg_in  <= d_reg_in;
      RYin    <= d_ryin;
      RZin    <= d_rzin;
      RZLOout <= d_rzlo;
      ops     <= d_ops;
    end
  end

`ifdef SEQ_MULDIV_EN
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      RZHIout <= 1'b0;
      LOin    <= 1'b0;
      HIin    <= 1'b0;
    end else begin
      RZHIout <= d_rzhi;
      LOin    <= d_loin;
      HIin    <= d_hiin;
    end
  end
`else
  assign RZHIout = 1'b0;
  assign LOin    = 1'b0;
  assign HIin    = 1'b0;
`endif

endmodule
